// File: rtl/word_unshift.sv
// word_unshift: accepts one WIDTH-bit word and replays it as WIDTH/CHUNK
// CHUNK-bit beats, most-significant chunk first, over a valid/ready handshake.
module word_unshift #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHUNK-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned BEATS = WIDTH / CHUNK;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             in_fire;
   logic             out_fire;

   // Outputs decoded from the registered state; in_ready also sees out_ready.
   always_comb begin
      out_valid = (state == SHIFT);
      busy      = (state == SHIFT);
      out_data  = sreg[WIDTH-1 -: CHUNK];
      out_last  = out_valid & (cnt == CW'(BEATS - 1));
      out_fire  = out_valid & out_ready;
      in_ready  = rst & ((state == IDLE) | (out_fire & out_last));
      in_fire   = in_valid & in_ready;
   end

   // State, shift register and beat counter; a new word wins over the last shift.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else if (in_fire) begin
         state <= SHIFT;
         sreg  <= in_data;
         cnt   <= '0;
      end else if (out_fire) begin
         sreg <= sreg << CHUNK;
         if (out_last) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_word_unshift.sv
// Bench for word_unshift: three instances (32/8, 16/16, 8/1) checked every
// cycle against a queue-of-pending-beats reference model.
module tb_word_unshift;

   logic clk = 1'b0;
   logic rst;

   logic        iv_a, ir_a, ov_a, or_a, ol_a, bz_a;
   logic [31:0] id_a;
   logic [7:0]  od_a;

   logic        iv_b, ir_b, ov_b, or_b, ol_b, bz_b;
   logic [15:0] id_b;
   logic [15:0] od_b;

   logic        iv_c, ir_c, ov_c, or_c, ol_c, bz_c;
   logic [7:0]  id_c;
   logic [0:0]  od_c;

   int ntests = 0;
   int nfail  = 0;

   // Pending beats per instance: bits [15:0] data, bit 16 last flag.
   int unsigned qa[$];
   int unsigned qb[$];
   int unsigned qc[$];

   always #5 clk = ~clk;

   word_unshift #(.WIDTH(32), .CHUNK(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
      .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_last(ol_a), .busy(bz_a));

   word_unshift #(.WIDTH(16), .CHUNK(16)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
      .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_last(ol_b), .busy(bz_b));

   word_unshift #(.WIDTH(8), .CHUNK(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
      .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .out_last(ol_c), .busy(bz_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int id);
      case (id)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   function automatic int unsigned qfront(input int id);
      if (qsize(id) == 0) return 0;
      case (id)
         0:       return qa[0];
         1:       return qb[0];
         default: return qc[0];
      endcase
   endfunction

   task automatic qpop(input int id);
      case (id)
         0:       void'(qa.pop_front());
         1:       void'(qb.pop_front());
         default: void'(qc.pop_front());
      endcase
   endtask

   task automatic qpush(input int id, input int unsigned e);
      case (id)
         0:       qa.push_back(e);
         1:       qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   // Split a word into its chunks, most significant first.
   task automatic load_word(input int id, input longint unsigned w, input int wd, input int ch);
      int nb;
      longint unsigned d;
      nb = wd / ch;
      for (int i = 0; i < nb; i++) begin
         d = (w >> (wd - ch * (i + 1))) & ((64'd1 << ch) - 64'd1);
         qpush(id, 32'(d) | ((i == nb - 1) ? 32'h1_0000 : 32'h0));
      end
   endtask

   function automatic logic exp_ready(input int id, input logic orr);
      return rst & ((qsize(id) == 0) | (orr & (qsize(id) == 1)));
   endfunction

   task automatic check_dut(input int id, input string nm, input logic ov, input logic [15:0] od,
                            input logic ol, input logic ir, input logic bz, input logic orr);
      logic ev;
      int unsigned f;
      ev = (qsize(id) != 0);
      f  = qfront(id);
      chk({nm, " out_valid"}, 32'(ov), 32'(ev));
      chk({nm, " busy"}, 32'(bz), 32'(ev));
      chk({nm, " in_ready"}, 32'(ir), 32'(exp_ready(id, orr)));
      if (ev) begin
         chk({nm, " out_data"}, 32'(od), 32'(f[15:0]));
         chk({nm, " out_last"}, 32'(ol), 32'(f[16]));
      end else begin
         chk({nm, " out_last"}, 32'(ol), 32'h0);
      end
   endtask

   // One clock: check all outputs, then advance the model across the edge.
   task automatic cycle();
      logic acc_a, acc_b, acc_c, xf_a, xf_b, xf_c;
      #1;
      check_dut(0, "a", ov_a, 16'(od_a), ol_a, ir_a, bz_a, or_a);
      check_dut(1, "b", ov_b, od_b,      ol_b, ir_b, bz_b, or_b);
      check_dut(2, "c", ov_c, 16'(od_c), ol_c, ir_c, bz_c, or_c);
      acc_a = iv_a & exp_ready(0, or_a);
      acc_b = iv_b & exp_ready(1, or_b);
      acc_c = iv_c & exp_ready(2, or_c);
      xf_a  = (qsize(0) != 0) & or_a;
      xf_b  = (qsize(1) != 0) & or_b;
      xf_c  = (qsize(2) != 0) & or_c;
      @(posedge clk);
      if (!rst) begin
         qa.delete();
         qb.delete();
         qc.delete();
      end else begin
         if (xf_a) qpop(0);
         if (xf_b) qpop(1);
         if (xf_c) qpop(2);
         if (acc_a) load_word(0, 64'(id_a), 32, 8);
         if (acc_b) load_word(1, 64'(id_b), 16, 16);
         if (acc_c) load_word(2, 64'(id_c), 8, 1);
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic check_cleared();
      chk("rst a out_data", 32'(od_a), 32'h0);
      chk("rst b out_data", 32'(od_b), 32'h0);
      chk("rst c out_data", 32'(od_c), 32'h0);
      chk("rst a out_valid", 32'(ov_a), 32'h0);
   endtask

   initial begin
      logic [0:0] seq[7];
      rst  = 1'b0;
      iv_a = 1'b0; id_a = '0; or_a = 1'b1;
      iv_b = 1'b0; id_b = '0; or_b = 1'b1;
      iv_c = 1'b0; id_c = '0; or_c = 1'b1;
      @(posedge clk);
      #1;
      // Reset held: in_ready must stay low, everything cleared.
      run(2);
      check_cleared();
      rst = 1'b1;
      run(1);

      // Plain serialization, MS chunk first.
      iv_a = 1'b1; id_a = 32'hA1B2C3D4;
      run(1);
      iv_a = 1'b0;
      run(6);

      // Back-pressure pattern.
      seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      iv_a = 1'b1; id_a = 32'hA1B2C3D4;
      run(1);
      iv_a = 1'b0;
      foreach (seq[i]) begin
         or_a = seq[i];
         run(1);
      end
      or_a = 1'b1;
      run(4);

      // Back-to-back words with in_valid held.
      iv_a = 1'b1; id_a = 32'h11223344;
      run(1);
      id_a = 32'h55667788;
      run(4);
      iv_a = 1'b0;
      run(6);

      // Reset mid-word after the second beat transfers.
      iv_a = 1'b1; id_a = 32'hA1B2C3D4;
      run(1);
      iv_a = 1'b0;
      run(2);
      rst = 1'b0;
      run(1);
      check_cleared();
      rst = 1'b1;
      run(2);
      iv_a = 1'b1; id_a = 32'hCAFEF00D;
      run(1);
      iv_a = 1'b0;
      run(6);

      // Single-beat words, second accepted as the first transfers.
      iv_b = 1'b1; id_b = 16'hBEEF;
      run(1);
      id_b = 16'h1234;
      run(1);
      iv_b = 1'b0;
      run(3);

      // Bit-serial.
      iv_c = 1'b1; id_c = 8'h96;
      run(1);
      iv_c = 1'b0;
      run(10);

      // Randomized traffic on all three instances.
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 59) != 0);
         iv_a = 1'($urandom_range(0, 1)); id_a = $urandom();
         or_a = ($urandom_range(0, 3) != 0);
         iv_b = 1'($urandom_range(0, 1)); id_b = 16'($urandom());
         or_b = ($urandom_range(0, 3) != 0);
         iv_c = 1'($urandom_range(0, 1)); id_c = 8'($urandom());
         or_c = ($urandom_range(0, 3) != 0);
         run(1);
      end
      rst = 1'b1;
      iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
      or_a = 1'b1; or_b = 1'b1; or_c = 1'b1;
      run(12);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/word_unshift.md
# word_unshift

Parallel-in, chunked-serial-out converter that mirrors the team's shift-in register path. It accepts one WIDTH-bit word over a valid/ready handshake and replays it as WIDTH/CHUNK consecutive CHUNK-bit beats, most-significant chunk first, on a second valid/ready handshake. It sits on the downstream side of wide datapath registers and feeds narrow links or serial consumers. It supports back-to-back words with no bubble and full back-pressure.

## Interface
- WIDTH, 32: input word width; must be an integer multiple of CHUNK.
- CHUNK, 8: output beat width; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-low (asserted = 0).
- in_valid  input  1  in_data holds a word to transfer.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to serialize.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  consumer accepts the beat this cycle.
- out_data  output  CHUNK  current beat, driven from the top CHUNK bits of the shift register.
- out_last  output  1  current beat is the final beat of its word.
- busy  output  1  a word is held, i.e. the FSM is in SHIFT.

## Operation
- BEATS = WIDTH/CHUNK. Beat counter width = max(1, clog2(BEATS)).
- FSM has two states.
  - IDLE: out_valid=0, in_ready=1.
  - SHIFT: out_valid=1, holding a word.
- Input accept: in_valid & in_ready in cycle N.
  - Shift register loads in_data; counter clears to 0.
  - State = SHIFT in cycle N+1.
- Beat transfer: out_valid & out_ready.
  - Not last: shift register shifts left by CHUNK with zero fill; counter increments.
  - Last (counter = BEATS-1):
    - If in_valid is also high, the new word loads in the same edge (back-to-back) and the block stays in SHIFT.
    - Otherwise the block returns to IDLE.
- in_ready = rst & (IDLE | (out_valid & out_ready & out_last)). This is a combinational path from out_ready; no other combinational in→out paths.
- out_last = out_valid & (counter == BEATS-1).
- out_valid low, out_ready high: no state change (don't-care).
- out_valid high, out_ready low: out_data, out_last and the counter hold stable. in_ready stays 0. in_data is ignored.
- BEATS = 1 (CHUNK = WIDTH): every beat has out_last=1, and out_data equals the loaded word.
- Reset (rst=0 at an edge) takes priority over every event, including mid-word. The partial word is discarded and no remaining beats are emitted.
- After reset:
  - State = IDLE, counter = 0, shift register = 0.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - in_ready=0 while rst=0, then 1 in the first cycle after rst rises.

## Timing
- Latency: word accepted at edge N; first beat is valid in the cycle after edge N.
- Throughput with out_ready held high: one word per BEATS cycles, no idle cycle between words when in_valid is held.
- Each out_ready-low cycle stretches the word by exactly one cycle.
- busy equals out_valid in every cycle.

## Test plan
- Load 0xA1B2C3D4 with out_ready=1 (WIDTH=32, CHUNK=8) -> beats A1, B2, C3, D4 on 4 consecutive cycles starting 1 cycle after accept; out_last only on D4; in_ready=1 only in the D4 cycle and in IDLE.
- Same word with out_ready toggling 1,0,0,1,0,1,1 -> the 4 beats appear in order; data and out_last are stable during every stall; no beat is dropped or duplicated.
- Words 0x11223344 then 0x55667788 with in_valid held high -> 8 consecutive beats 11..44, 55..88; out_last on 44 and 88; second accept coincides with the 44 transfer; zero bubble cycles.
- rst=0 after the B2 beat is transferred -> next cycle out_valid=0, out_data=0, busy=0; C3/D4 are never emitted; the first word after release serializes normally.
- WIDTH=16, CHUNK=16, load 0xBEEF -> single beat 0xBEEF with out_last=1; a second word can be accepted in the same cycle the beat transfers.
- WIDTH=8, CHUNK=1, load 0x96 -> bits 1,0,0,1,0,1,1,0 over 8 cycles; out_last only on the 8th.
